// File: rtl/map_ss_pkg.sv
// Shared types and defaults for the mapper save-state sequencer.
// Holds the sequencer state enum and default sizing constants.
package map_ss_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SAVE     = 3'd1,
        LD_FETCH = 3'd2,
        LD_ARM   = 3'd3,
        VERIFY   = 3'd4,
        DONE     = 3'd5
    } ss_state_e;

    localparam int SS_IDX_ADDR_DEF = 127;
    localparam int SS_LEN_DEF      = 128;
    localparam int SS_TIMEOUT_DEF  = 4096;

endpackage

// File: rtl/m2_fall_det.sv
// M2 synchroniser and falling-edge detector for the system clock domain.
// Ports: clk, sys_rst (async, active-high), m2 (async in), fall_p (1-clk pulse).
module m2_fall_det (
    input  logic clk,
    input  logic sys_rst,
    input  logic m2,
    output logic fall_p
);

    logic [2:0] sync_q, sync_d;
    logic       fall_q, fall_d;

    // [0],[1] synchronise; [2] is the previous synchronised level.
    always_comb begin
        sync_d = {sync_q[1:0], m2};
        fall_d = sync_q[2] & ~sync_q[1];
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_q <= '0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            fall_q <= fall_d;
        end
    end

    assign fall_p = fall_q;

endmodule

// File: rtl/map_ss_seq.sv
// Save-state sequencer: copies mapper registers to/from a buffer RAM,
// stepping the mapper save-state port in lock-step with M2 falling edges.
// Ports: clk/sys_rst/m2, req_save/req_load, busy/done/err status,
// ss_* mapper save-state port, buf_* buffer RAM port, map_idx_o, verify_err.
// Optional: define MAP_SS_VERIFY_EN to add a read-back compare after load.
module map_ss_seq
    import map_ss_pkg::*;
#(
    parameter int SS_LEN   = SS_LEN_DEF,
    parameter int AW       = 7,
    parameter int IDX_ADDR = SS_IDX_ADDR_DEF,
    parameter int TIMEOUT  = SS_TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic          m2,
    input  logic          req_save,
    input  logic          req_load,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          ss_act,
    output logic          ss_we,
    output logic [7:0]    ss_addr,
    output logic [7:0]    ss_wdat,
    input  logic [7:0]    ss_rdat,
    output logic [AW-1:0] buf_addr,
    output logic          buf_we,
    output logic [7:0]    buf_wdat,
    input  logic [7:0]    buf_rdat,
    output logic [7:0]    map_idx_o,
    output logic          verify_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    LAST = 8'(SS_LEN - 1);
    localparam logic [7:0]    IDX  = 8'(IDX_ADDR);
    localparam logic [TW-1:0] TMO  = TW'(TIMEOUT);

    ss_state_e     state_q, state_d;
    logic [7:0]    ss_addr_q, ss_addr_d, addr_nxt;
    logic          ss_we_q, ss_we_d;
    logic [7:0]    ss_wdat_q, ss_wdat_d;
    logic [AW-1:0] buf_addr_q, buf_addr_d;
    logic          buf_we_q, buf_we_d;
    logic [7:0]    buf_wdat_q, buf_wdat_d;
    logic [7:0]    map_idx_q, map_idx_d;
    logic          err_q, err_d;
    logic          armed_q, armed_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          fall_p;
    logic          active;

`ifdef MAP_SS_VERIFY_EN
    logic          vfy_q, vfy_d;
`endif

    m2_fall_det u_fall (
        .clk    (clk),
        .sys_rst(sys_rst),
        .m2     (m2),
        .fall_p (fall_p)
    );

    assign active = (state_q == SAVE) || (state_q == LD_FETCH) ||
                    (state_q == LD_ARM) || (state_q == VERIFY);

    always_comb begin
        state_d    = state_q;
        ss_addr_d  = ss_addr_q;
        ss_we_d    = ss_we_q;
        ss_wdat_d  = ss_wdat_q;
        buf_addr_d = buf_addr_q;
        buf_we_d   = 1'b0;
        buf_wdat_d = buf_wdat_q;
        map_idx_d  = map_idx_q;
        err_d      = err_q;
        armed_d    = armed_q;
        addr_nxt   = ss_addr_q + 8'd1;
        tmo_d      = '0;
`ifdef MAP_SS_VERIFY_EN
        vfy_d      = vfy_q;
`endif
        if (active && !fall_p) begin
            tmo_d = tmo_q + TW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (req_save || req_load) begin
                    ss_addr_d  = '0;
                    buf_addr_d = '0;
                    ss_we_d    = 1'b0;
                    armed_d    = 1'b0;
                    err_d      = 1'b0;
`ifdef MAP_SS_VERIFY_EN
                    vfy_d      = 1'b0;
`endif
                    state_d    = req_save ? SAVE : LD_FETCH;
                end
            end
            SAVE: begin
                if (fall_p) begin
                    buf_we_d   = 1'b1;
                    buf_addr_d = ss_addr_q[AW-1:0];
                    buf_wdat_d = ss_rdat;
                    if (ss_addr_q == IDX) begin
                        map_idx_d = ss_rdat;
                    end
                    if (ss_addr_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        ss_addr_d = addr_nxt;
                    end
                end
            end
            LD_FETCH: begin
                ss_we_d = 1'b0;
                if (fall_p) begin
                    armed_d = 1'b1;
                end
                state_d = LD_ARM;
            end
            LD_ARM: begin
                // Raise ss_we only once an M2 fall has been seen, so the
                // first write cannot race a fall already in flight.
                if (!ss_we_q && armed_q) begin
                    ss_wdat_d = buf_rdat;
                    ss_we_d   = 1'b1;
                end
                if (fall_p) begin
                    armed_d = 1'b1;
                    if (ss_we_q) begin
                        ss_we_d = 1'b0;
                        if (ss_addr_q == LAST) begin
`ifdef MAP_SS_VERIFY_EN
                            ss_addr_d  = '0;
                            buf_addr_d = '0;
                            state_d    = VERIFY;
`else
                            state_d    = DONE;
`endif
                        end else begin
                            ss_addr_d  = addr_nxt;
                            buf_addr_d = addr_nxt[AW-1:0];
                            state_d    = LD_FETCH;
                        end
                    end
                end
            end
`ifdef MAP_SS_VERIFY_EN
            VERIFY: begin
                // buf_addr equals ss_addr, so buf_rdat has settled well
                // before the next fall.
                if (fall_p) begin
                    if (ss_rdat != buf_rdat) begin
                        vfy_d = 1'b1;
                    end
                    if (ss_addr_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        ss_addr_d  = addr_nxt;
                        buf_addr_d = addr_nxt[AW-1:0];
                    end
                end
            end
`endif
            DONE: begin
                ss_we_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (active && tmo_q == TMO) begin
            err_d    = 1'b1;
            ss_we_d  = 1'b0;
            buf_we_d = 1'b0;
            state_d  = DONE;
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            ss_addr_q  <= '0;
            ss_we_q    <= 1'b0;
            ss_wdat_q  <= '0;
            buf_addr_q <= '0;
            buf_we_q   <= 1'b0;
            buf_wdat_q <= '0;
            map_idx_q  <= '0;
            err_q      <= 1'b0;
            armed_q    <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            ss_addr_q  <= ss_addr_d;
            ss_we_q    <= ss_we_d;
            ss_wdat_q  <= ss_wdat_d;
            buf_addr_q <= buf_addr_d;
            buf_we_q   <= buf_we_d;
            buf_wdat_q <= buf_wdat_d;
            map_idx_q  <= map_idx_d;
            err_q      <= err_d;
            armed_q    <= armed_d;
            tmo_q      <= tmo_d;
        end
    end

`ifdef MAP_SS_VERIFY_EN
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            vfy_q <= 1'b0;
        end else begin
            vfy_q <= vfy_d;
        end
    end
    assign verify_err = vfy_q;
`else
    assign verify_err = 1'b0;
`endif

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign ss_act    = active;
    assign ss_we     = ss_we_q;
    assign ss_addr   = ss_addr_q;
    assign ss_wdat   = ss_wdat_q;
    assign buf_addr  = buf_addr_q;
    assign buf_we    = buf_we_q;
    assign buf_wdat  = buf_wdat_q;
    assign map_idx_o = map_idx_q;

endmodule

// File: tb/tb_map_ss_seq.sv
// Directed bench for map_ss_seq with a mapper register model
// and a 1-cycle-latency buffer RAM model.
module tb_map_ss_seq;

    logic       clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       m2 = 1'b1;
    logic       m2_hold = 1'b0;
    logic       req_save = 1'b0;
    logic       req_load = 1'b0;
    logic       busy, done, err;
    logic       ss_act, ss_we;
    logic [7:0] ss_addr, ss_wdat, ss_rdat;
    logic [6:0] buf_addr;
    logic       buf_we;
    logic [7:0] buf_wdat;
    logic [7:0] buf_rdat = 8'h00;
    logic [7:0] map_idx_o;
    logic       verify_err;

    logic [7:0] regs [256];
    logic [7:0] bufm [128];
    logic       corrupt = 1'b0;
    int         cyc = 0;
    int         last_fall = 0;
    int         wr_cnt = 0;
    int         bwe_cnt = 0;
    int         done_cnt = 0;
    int         checks = 0;
    int         failures = 0;

    map_ss_seq dut (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .m2        (m2),
        .req_save  (req_save),
        .req_load  (req_load),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ss_act    (ss_act),
        .ss_we     (ss_we),
        .ss_addr   (ss_addr),
        .ss_wdat   (ss_wdat),
        .ss_rdat   (ss_rdat),
        .buf_addr  (buf_addr),
        .buf_we    (buf_we),
        .buf_wdat  (buf_wdat),
        .buf_rdat  (buf_rdat),
        .map_idx_o (map_idx_o),
        .verify_err(verify_err)
    );

    always #5 clk = ~clk;

    initial begin
        #37;
        forever begin
            #100;
            m2 = m2_hold ? 1'b1 : ~m2;
        end
    end

    assign ss_rdat = regs[ss_addr];

    always @(negedge m2) begin
        last_fall = cyc;
        if (ss_act && ss_we) begin
            if (corrupt && ss_addr == 8'd1) regs[ss_addr] = ss_wdat ^ 8'h80;
            else regs[ss_addr] = ss_wdat;
            wr_cnt = wr_cnt + 1;
        end
    end

    always @(posedge clk) begin
        buf_rdat <= bufm[buf_addr];
        if (buf_we) bufm[buf_addr] = buf_wdat;
        cyc <= cyc + 1;
        if (buf_we) bwe_cnt <= bwe_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic wait_done(input int budget, output bit ok);
        int start;
        start = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse(input bit s, input bit l);
        @(negedge clk);
        req_save = s;
        req_load = l;
        @(negedge clk);
        req_save = 1'b0;
        req_load = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] obs;
        @(negedge clk);
        obs = {busy, done, err, ss_act, ss_we, buf_we, verify_err,
               ss_addr, ss_wdat, buf_addr, buf_wdat};
        checks++;
        if (obs !== 32'd0) begin
            failures++;
            $display("FAIL reset_outs got=%h exp=0", obs);
        end
        checks++;
        if (map_idx_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_idx got=%h exp=00", map_idx_o);
        end
        sys_rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_save;
        int b0, d0;
        bit ok;
        for (int i = 0; i < 256; i++) regs[i] = 8'hFF;
        for (int i = 0; i < 128; i++) bufm[i] = 8'h00;
        regs[0] = 8'h25;
        regs[1] = 8'h03;
        regs[127] = 8'hE6;
        b0 = bwe_cnt;
        d0 = done_cnt;
        pulse(1'b1, 1'b0);
        checks++;
        if (ss_act !== 1'b1 || ss_we !== 1'b0 || ss_addr !== 8'd0) begin
            failures++;
            $display("FAIL save_entry act=%b we=%b addr=%h exp 1 0 00",
                     ss_act, ss_we, ss_addr);
        end
        wait_done(4000, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL save_done got=timeout exp=done");
        end
        checks++;
        if (bufm[0] !== 8'h25 || bufm[1] !== 8'h03 || bufm[2] !== 8'hFF) begin
            failures++;
            $display("FAIL save_buf_lo got=%h %h %h exp=25 03 FF",
                     bufm[0], bufm[1], bufm[2]);
        end
        checks++;
        if (bufm[126] !== 8'hFF || bufm[127] !== 8'hE6) begin
            failures++;
            $display("FAIL save_buf_hi got=%h %h exp=FF E6",
                     bufm[126], bufm[127]);
        end
        checks++;
        if (map_idx_o !== 8'hE6) begin
            failures++;
            $display("FAIL save_idx got=%h exp=E6", map_idx_o);
        end
        checks++;
        if (bwe_cnt - b0 != 128) begin
            failures++;
            $display("FAIL save_bwe_cnt got=%0d exp=128", bwe_cnt - b0);
        end
        checks++;
        if (done_cnt - d0 != 1 || ss_act !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL save_end done=%0d act=%b err=%b exp 1 0 0",
                     done_cnt - d0, ss_act, err);
        end
    endtask

    task automatic test_load;
        int w0;
        bit ok;
        for (int i = 0; i < 256; i++) regs[i] = 8'h00;
        bufm[0] = 8'h5A;
        bufm[1] = 8'h01;
        w0 = wr_cnt;
        pulse(1'b0, 1'b1);
        wait_done(4000, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL load_done got=timeout exp=done");
        end
        checks++;
        if (regs[0] !== 8'h5A || regs[1] !== 8'h01) begin
            failures++;
            $display("FAIL load_regs_lo got=%h %h exp=5A 01", regs[0], regs[1]);
        end
        checks++;
        if (regs[2] !== 8'hFF || regs[127] !== 8'hE6) begin
            failures++;
            $display("FAIL load_regs_hi got=%h %h exp=FF E6",
                     regs[2], regs[127]);
        end
        checks++;
        if (wr_cnt - w0 != 128) begin
            failures++;
            $display("FAIL load_writes got=%0d exp=128", wr_cnt - w0);
        end
        checks++;
        if (ss_act !== 1'b0 || ss_we !== 1'b0 || verify_err !== 1'b0) begin
            failures++;
            $display("FAIL load_end act=%b we=%b verr=%b exp 0 0 0",
                     ss_act, ss_we, verify_err);
        end
    endtask

    task automatic test_back_to_back;
        int b0, d0, w0;
        bit ok;
        b0 = bwe_cnt;
        d0 = done_cnt;
        w0 = wr_cnt;
        pulse(1'b1, 1'b1);
        repeat (500) @(negedge clk);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        wait_done(4000, ok);
        repeat (300) @(negedge clk);
        checks++;
        if (!ok || bwe_cnt - b0 != 128 || wr_cnt != w0) begin
            failures++;
            $display("FAIL collide_save ok=%b bwe=%0d wr=%0d exp 1 128 0",
                     ok, bwe_cnt - b0, wr_cnt - w0);
        end
        checks++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL collide_once done=%0d busy=%b exp 1 0",
                     done_cnt - d0, busy);
        end
    endtask

    task automatic test_timeout;
        int d0, t_err;
        bit ok;
        d0 = done_cnt;
        t_err = -1;
        pulse(1'b1, 1'b0);
        repeat (1000) @(negedge clk);
        m2_hold = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (err === 1'b1) begin
                t_err = cyc;
                break;
            end
        end
        checks++;
        if (t_err < 0 || t_err - last_fall < 4090 || t_err - last_fall > 4110) begin
            failures++;
            $display("FAIL tmo_time got=%0d exp=~4100", t_err - last_fall);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (ss_act !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL tmo_abort act=%b busy=%b done=%0d exp 0 0 1",
                     ss_act, busy, done_cnt - d0);
        end
        m2_hold = 1'b0;
        pulse(1'b0, 1'b1);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL tmo_clear err=%b busy=%b exp 0 1", err, busy);
        end
        wait_done(4000, ok);
        checks++;
        if (!ok || err !== 1'b0) begin
            failures++;
            $display("FAIL tmo_reload ok=%b err=%b exp 1 0", ok, err);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] obs;
        bit hit, ok;
        hit = 1'b0;
        for (int i = 0; i < 256; i++) regs[i] = 8'h00;
        pulse(1'b0, 1'b1);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (ss_addr == 8'd40 && ss_we === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL rst_reach got=timeout exp=addr40_armed");
        end
        #2 sys_rst = 1'b1;
        #1;
        obs = {busy, done, err, ss_act, ss_we, buf_we, verify_err,
               ss_addr, ss_wdat, buf_addr, buf_wdat};
        checks++;
        if (obs !== 32'd0 || map_idx_o !== 8'h00) begin
            failures++;
            $display("FAIL rst_async got=%h idx=%h exp=0", obs, map_idx_o);
        end
        @(negedge clk);
        sys_rst = 1'b0;
        pulse(1'b0, 1'b1);
        checks++;
        if (ss_addr !== 8'd0 || ss_act !== 1'b1) begin
            failures++;
            $display("FAIL rst_restart addr=%h act=%b exp 00 1", ss_addr, ss_act);
        end
        wait_done(4000, ok);
        checks++;
        if (!ok || regs[0] !== 8'h5A || regs[127] !== 8'hE6) begin
            failures++;
            $display("FAIL rst_reload ok=%b r0=%h r127=%h exp 1 5A E6",
                     ok, regs[0], regs[127]);
        end
    endtask

`ifdef MAP_SS_VERIFY_EN
    task automatic test_verify;
        bit ok;
        corrupt = 1'b1;
        pulse(1'b0, 1'b1);
        wait_done(8000, ok);
        corrupt = 1'b0;
        checks++;
        if (!ok || verify_err !== 1'b1) begin
            failures++;
            $display("FAIL verify_bad ok=%b verr=%b exp 1 1", ok, verify_err);
        end
        pulse(1'b0, 1'b1);
        wait_done(8000, ok);
        checks++;
        if (!ok || verify_err !== 1'b0) begin
            failures++;
            $display("FAIL verify_clean ok=%b verr=%b exp 1 0", ok, verify_err);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) regs[i] = 8'h00;
        for (int i = 0; i < 128; i++) bufm[i] = 8'h00;
        test_reset();
        test_save();
        test_load();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
`ifdef MAP_SS_VERIFY_EN
        test_verify();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
